// File: rtl/arb_pkg.sv
// Shared types and constants for the core memory-port arbiter.
// Provides the owner encoding, bus widths, the instruction-side default
// byte enable and small sizing helpers used by the arbiter and its FIFO.
package arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Which core port a transaction belongs to
  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Fetches are always full-word reads
  localparam logic [BE_W-1:0] INSTR_BE = 4'hF;

  // Counter width able to hold 0..depth
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width, at least one bit even for a single-entry FIFO
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// One-bit FIFO recording which port owns each outstanding transaction.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - enqueue din (ignored when full)
//   pop, dout   - dequeue; dout is the current head (ignored when empty)
//   full, empty - occupancy flags
//   count       - number of entries held
module arb_owner_fifo
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned SLOTS = 1 << PTR_W;

  logic [SLOTS-1:0] slot_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  // Wrap modulo DEPTH rather than modulo the pointer width
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = slot_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        slot_q[wr_ptr_q] <= din;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one memory port.
// Arbitrates between the two requesters, keeps the chosen request stable
// until granted, and routes in-order responses back to the issuing port.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   instr_*            - fetch port (req/gnt/addr, rvalid/rdata/err)
//   data_*             - data port (req/gnt/we/be/addr/wdata, rvalid/rdata/err)
//   mem_*              - merged memory port towards the RAM / bus slave
//   unexp_rsp_o        - registered pulse: response arrived with nothing outstanding
module core_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_PRIORITY   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req_i,
  output logic              instr_gnt_o,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i,
  output logic              unexp_rsp_o
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  owner_e           owner_c;
  owner_e           locked_owner_q;
  owner_e           rr_last_q;
  owner_e           head_c;
  logic             locked_q;
  logic             unexp_q;
  logic             sel_req_c;
  logic             accept_c;
  logic             pop_c;
  logic             fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Owner selection: a held lock wins, otherwise priority or round-robin
  always_comb begin
    owner_c = OWNER_INSTR;
    if (locked_q) begin
      owner_c = locked_owner_q;
    end else if (data_req_i && !instr_req_i) begin
      owner_c = OWNER_DATA;
    end else if (data_req_i && instr_req_i) begin
      if (DATA_PRIORITY) begin
        owner_c = OWNER_DATA;
      end else begin
        owner_c = (rr_last_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
      end
    end
  end

  // A locked owner that drops its request gets nothing; the lock then clears
  assign sel_req_c = (owner_c == OWNER_DATA) ? data_req_i : instr_req_i;
  assign mem_req_o = sel_req_c & ~fifo_full;
  assign accept_c  = mem_req_o & mem_gnt_i;

  // Request payload mux; idle port drives zeros
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_req_c) begin
      if (owner_c == OWNER_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = INSTR_BE;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  assign instr_gnt_o = accept_c & (owner_c == OWNER_INSTR);
  assign data_gnt_o  = accept_c & (owner_c == OWNER_DATA);

  // Response routing by the owner recorded at accept time
  assign pop_c          = mem_rvalid_i & ~fifo_empty;
  assign head_c         = owner_e'(fifo_dout);
  assign instr_rvalid_o = pop_c & (head_c == OWNER_INSTR);
  assign data_rvalid_o  = pop_c & (head_c == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign unexp_rsp_o    = unexp_q;

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_c),
    .pop   (mem_rvalid_i),
    .din   (owner_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Lock, round-robin history and unexpected-response pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q       <= 1'b0;
      locked_owner_q <= OWNER_INSTR;
      rr_last_q      <= OWNER_DATA;
      unexp_q        <= 1'b0;
    end else begin
      locked_q <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) begin
        locked_owner_q <= owner_c;
      end
      if (accept_c) begin
        rr_last_q <= owner_c;
      end
      unexp_q <= mem_rvalid_i & (fifo_count == '0);
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: instance 0 uses fixed data
// priority, instance 1 round-robin, both with two outstanding slots.
module tb_core_mem_arbiter;

  typedef struct packed {
    logic        side;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        instr_req    [2];
  logic [31:0] instr_addr   [2];
  logic        data_req     [2];
  logic        data_we      [2];
  logic [3:0]  data_be      [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic        mem_gnt      [2];
  logic        mem_rvalid   [2];
  logic [31:0] mem_rdata    [2];
  logic        mem_err      [2];

  logic        instr_gnt    [2];
  logic        instr_rvalid [2];
  logic [31:0] instr_rdata  [2];
  logic        instr_err    [2];
  logic        data_gnt     [2];
  logic        data_rvalid  [2];
  logic [31:0] data_rdata   [2];
  logic        data_err     [2];
  logic        mem_req      [2];
  logic        mem_we       [2];
  logic [3:0]  mem_be       [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic        unexp        [2];

  int   n_chk;
  int   n_fail;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  core_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) u_dut_prio (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req[0]), .instr_gnt_o(instr_gnt[0]), .instr_addr_i(instr_addr[0]),
    .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]), .instr_err_o(instr_err[0]),
    .data_req_i(data_req[0]), .data_gnt_o(data_gnt[0]), .data_we_i(data_we[0]),
    .data_be_i(data_be[0]), .data_addr_i(data_addr[0]), .data_wdata_i(data_wdata[0]),
    .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]), .data_err_o(data_err[0]),
    .mem_req_o(mem_req[0]), .mem_gnt_i(mem_gnt[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rvalid_i(mem_rvalid[0]),
    .mem_rdata_i(mem_rdata[0]), .mem_err_i(mem_err[0]), .unexp_rsp_o(unexp[0])
  );

  core_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) u_dut_rr (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req[1]), .instr_gnt_o(instr_gnt[1]), .instr_addr_i(instr_addr[1]),
    .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]), .instr_err_o(instr_err[1]),
    .data_req_i(data_req[1]), .data_gnt_o(data_gnt[1]), .data_we_i(data_we[1]),
    .data_be_i(data_be[1]), .data_addr_i(data_addr[1]), .data_wdata_i(data_wdata[1]),
    .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]), .data_err_o(data_err[1]),
    .mem_req_o(mem_req[1]), .mem_gnt_i(mem_gnt[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rvalid_i(mem_rvalid[1]),
    .mem_rdata_i(mem_rdata[1]), .mem_err_i(mem_err[1]), .unexp_rsp_o(unexp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    instr_req[k]  = 1'b0;
    instr_addr[k] = '0;
    data_req[k]   = 1'b0;
    data_we[k]    = 1'b0;
    data_be[k]    = '0;
    data_addr[k]  = '0;
    data_wdata[k] = '0;
    mem_gnt[k]    = 1'b0;
    mem_rvalid[k] = 1'b0;
    mem_rdata[k]  = '0;
    mem_err[k]    = 1'b0;
  endtask

  task automatic push_exp(input int k, input logic side, input logic [31:0] d);
    exp_t e;
    e.side  = side;
    e.rdata = d;
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Scoreboard side: every forwarded response must match the oldest expectation
  task automatic check_rsp(input int k);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    e  = '0;
    if (k == 0 && exp_q0.size() > 0) begin
      e  = exp_q0.pop_front();
      ok = 1'b1;
    end else if (k == 1 && exp_q1.size() > 0) begin
      e  = exp_q1.pop_front();
      ok = 1'b1;
    end
    if (!ok) begin
      chk("rsp_unexpected", 32'(instr_rvalid[k] | data_rvalid[k]), 32'd0);
    end else begin
      chk("rsp_side", 32'(data_rvalid[k]), 32'(e.side));
      chk("rsp_one_hot", 32'(instr_rvalid[k] & data_rvalid[k]), 32'd0);
      chk("rsp_rdata", data_rvalid[k] ? data_rdata[k] : instr_rdata[k], e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (instr_rvalid[k] || data_rvalid[k]) check_rsp(k);
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle(0);
    idle(1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle state
    smp();
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_req", 32'(mem_req[k]), 32'd0);
      chk("rst_gnt", 32'({instr_gnt[k], data_gnt[k]}), 32'd0);
      chk("rst_be", 32'(mem_be[k]), 32'd0);
      chk("rst_addr", mem_addr[k], 32'd0);
      chk("rst_unexp", 32'(unexp[k]), 32'd0);
    end

    // Single fetch, response two cycles after grant
    cyc();
    instr_req[0] = 1'b1; instr_addr[0] = 32'h0000_0100; mem_gnt[0] = 1'b1;
    push_exp(0, 1'b0, 32'hDEAD_BEEF);
    smp();
    chk("f_mem_req", 32'(mem_req[0]), 32'd1);
    chk("f_instr_gnt", 32'(instr_gnt[0]), 32'd1);
    chk("f_data_gnt", 32'(data_gnt[0]), 32'd0);
    chk("f_addr", mem_addr[0], 32'h0000_0100);
    chk("f_we_be", 32'({mem_we[0], mem_be[0]}), 32'h0F);
    cyc(); idle(0);
    cyc(); mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'hDEAD_BEEF;
    smp();
    chk("f_instr_rvalid", 32'(instr_rvalid[0]), 32'd1);
    chk("f_data_rvalid", 32'(data_rvalid[0]), 32'd0);

    // Contention with data priority
    cyc(); idle(0);
    instr_req[0] = 1'b1; instr_addr[0] = 32'h0000_0300;
    data_req[0] = 1'b1; data_addr[0] = 32'h2000_0004; data_we[0] = 1'b1;
    data_be[0] = 4'b0011; data_wdata[0] = 32'h0000_1234; mem_gnt[0] = 1'b1;
    push_exp(0, 1'b1, 32'h2222_0000);
    smp();
    chk("p_data_gnt", 32'(data_gnt[0]), 32'd1);
    chk("p_instr_gnt", 32'(instr_gnt[0]), 32'd0);
    chk("p_we_be", 32'({mem_we[0], mem_be[0]}), 32'h13);
    chk("p_addr", mem_addr[0], 32'h2000_0004);
    chk("p_wdata", mem_wdata[0], 32'h0000_1234);
    cyc(); data_req[0] = 1'b0;
    push_exp(0, 1'b0, 32'h3333_0000);
    smp();
    chk("p2_instr_gnt", 32'(instr_gnt[0]), 32'd1);
    chk("p2_we_be", 32'({mem_we[0], mem_be[0]}), 32'h0F);
    chk("p2_addr", mem_addr[0], 32'h0000_0300);
    chk("p2_wdata", mem_wdata[0], 32'd0);
    cyc(); idle(0); mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'h2222_0000;
    cyc(); mem_rdata[0] = 32'h3333_0000; mem_err[0] = 1'b1;
    smp();
    chk("p_err_bcast", 32'({instr_err[0], data_err[0]}), 32'h3);
    cyc(); idle(0);

    // Round-robin with continuous contention and back-to-back responses
    for (int i = 0; i < 6; i++) begin
      cyc();
      instr_req[1] = 1'b1; instr_addr[1] = 32'h1000 + 32'(i);
      data_req[1] = 1'b1; data_addr[1] = 32'h2000 + 32'(i); mem_gnt[1] = 1'b1;
      mem_rvalid[1] = (i > 0);
      mem_rdata[1] = (i > 0) ? 32'hA000_0000 + 32'(i - 1) : 32'd0;
      push_exp(1, 1'(i % 2), 32'hA000_0000 + 32'(i));
      smp();
      chk("rr_instr_gnt", 32'(instr_gnt[1]), 32'(i % 2 == 0));
      chk("rr_data_gnt", 32'(data_gnt[1]), 32'(i % 2 == 1));
      chk("rr_addr", mem_addr[1], (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
    end
    cyc(); idle(1); mem_rvalid[1] = 1'b1; mem_rdata[1] = 32'hA000_0005;
    cyc(); idle(1);

    // Lock holds the instruction request while data (higher priority) waits
    for (int c = 1; c <= 3; c++) begin
      cyc();
      instr_req[0] = 1'b1; instr_addr[0] = 32'h0000_0400;
      if (c >= 2) begin
        data_req[0] = 1'b1; data_addr[0] = 32'h0000_0500; data_be[0] = 4'hC;
      end
      smp();
      chk("lk_addr", mem_addr[0], 32'h0000_0400);
      chk("lk_no_gnt", 32'({instr_gnt[0], data_gnt[0]}), 32'd0);
    end
    cyc(); mem_gnt[0] = 1'b1;
    push_exp(0, 1'b0, 32'h4444_0000);
    smp();
    chk("lk_instr_gnt", 32'(instr_gnt[0]), 32'd1);
    chk("lk_addr_gnt", mem_addr[0], 32'h0000_0400);
    cyc(); instr_req[0] = 1'b0;
    push_exp(0, 1'b1, 32'h5555_0000);
    smp();
    chk("lk_data_gnt", 32'(data_gnt[0]), 32'd1);
    chk("lk_data_addr", mem_addr[0], 32'h0000_0500);

    // FIFO full blocks requests, even with a same-cycle response
    cyc(); idle(0);
    instr_req[0] = 1'b1; instr_addr[0] = 32'h0000_0600; mem_gnt[0] = 1'b1;
    smp();
    chk("full_req", 32'(mem_req[0]), 32'd0);
    chk("full_gnt", 32'(instr_gnt[0]), 32'd0);
    cyc(); mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'h4444_0000;
    smp();
    chk("full_rv_req", 32'(mem_req[0]), 32'd0);
    chk("full_rv_gnt", 32'(instr_gnt[0]), 32'd0);
    cyc(); mem_rvalid[0] = 1'b0; mem_rdata[0] = '0;
    push_exp(0, 1'b0, 32'h6666_0000);
    smp();
    chk("unfull_req", 32'(mem_req[0]), 32'd1);
    chk("unfull_gnt", 32'(instr_gnt[0]), 32'd1);
    cyc(); idle(0); mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'h5555_0000;
    cyc(); mem_rdata[0] = 32'h6666_0000;
    cyc(); idle(0);

    // Response with nothing outstanding
    cyc(); mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'h0000_0055;
    smp();
    chk("ux_no_rvalid", 32'({instr_rvalid[0], data_rvalid[0]}), 32'd0);
    chk("ux_not_yet", 32'(unexp[0]), 32'd0);
    cyc(); idle(0);
    smp();
    chk("ux_pulse", 32'(unexp[0]), 32'd1);
    cyc();
    smp();
    chk("ux_pulse_end", 32'(unexp[0]), 32'd0);

    // Reset mid-transaction; the late response becomes unexpected
    cyc(); instr_req[0] = 1'b1; instr_addr[0] = 32'h0000_0700; mem_gnt[0] = 1'b1;
    smp();
    chk("mr_gnt", 32'(instr_gnt[0]), 32'd1);
    cyc(); idle(0); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); mem_rvalid[0] = 1'b1; mem_rdata[0] = 32'h0000_0077;
    smp();
    chk("mr_no_rvalid", 32'({instr_rvalid[0], data_rvalid[0]}), 32'd0);
    cyc(); idle(0);
    smp();
    chk("mr_unexp", 32'(unexp[0]), 32'd1);
    cyc();
    smp();
    chk("mr_unexp_end", 32'(unexp[0]), 32'd0);

    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Merges the core's instruction-fetch and data-access req/gnt/rvalid ports onto one memory port, so a single-port RAM or a single bus slave can serve the whole core.
- Sits between the processor core top level and the memory/bus interconnect.
- Arbitrates requests, holds the winner until it is granted, and tracks outstanding transactions so in-order responses return to the requester that issued them.

Parameters:
- MAX_OUTSTANDING, 2, depth of the response-owner FIFO; power of two, 1..8.
- DATA_PRIORITY, 1, 1 = fixed priority (data beats instruction); 0 = round-robin.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_addr_i  in  32  fetch address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_we_i  in  1  data write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data bus error
- mem_req_o  out  1  merged request
- mem_gnt_i  in  1  merged grant
- mem_we_o  out  1  merged write enable
- mem_be_o  out  4  merged byte enables
- mem_addr_o  out  32  merged address
- mem_wdata_o  out  32  merged write data
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  32  response data
- mem_err_i  in  1  response error
- unexp_rsp_o  out  1  registered 1-cycle pulse: rvalid received with no outstanding transaction

Behaviour:
- Reset (async, rst_n low):
  - FIFO count=0, pointers=0, lock clear.
  - Round-robin pointer favours instruction first.
  - unexp_rsp_o=0.
  - All combinational outputs are 0 when inputs are idle.
- Owner selection (combinational):
  - If locked, owner = locked_owner.
  - Else with a single requester, that requester wins.
  - On contention: DATA_PRIORITY=1 → data wins; DATA_PRIORITY=0 → the requester not granted last wins.
- full = (count == MAX_OUTSTANDING).
  - mem_req_o = (instr_req_i | data_req_i) & !full.
  - A same-cycle mem_rvalid_i does not unblock full.
- Request muxing:
  - mem_addr/we/be/wdata come from the owner.
  - An instruction owner drives we=0, be=4'hF, wdata=0.
- Grants: <owner>_gnt_o = mem_gnt_i & mem_req_o & owner match; the non-owner's gnt is 0. Zero-cycle grant path.
- Lock (OBI address stability):
  - If mem_req_o & !mem_gnt_i, register lock=1 with locked_owner=owner.
  - Clear lock on the cycle mem_gnt_i is seen.
  - A requester withdrawing its req while locked is a protocol violation; the lock is cleared and there is no grant.
- Accept: mem_req_o & mem_gnt_i pushes the owner bit into the FIFO and updates the round-robin pointer.
- Response:
  - mem_rvalid_i with count>0 pops the FIFO.
  - <head>_rvalid_o = mem_rvalid_i; the other rvalid stays 0.
  - rdata/err are broadcast to both sides.
  - No added latency.
- Simultaneous accept and response: push and pop in the same cycle, count unchanged, pointers wrap modulo MAX_OUTSTANDING.
- mem_rvalid_i with count==0:
  - Dropped; neither rvalid asserts.
  - unexp_rsp_o=1 on the next cycle, for one cycle.
- Reset mid-transaction: all tracking is lost; late responses after reset produce unexp_rsp_o.

Decomposition:
- Shared package `arb_pkg`:
  - owner_e {OWNER_INSTR=1'b0, OWNER_DATA=1'b1}.
  - localparam for the instruction-side default be (4'hF).
- Sub-module `arb_owner_fifo`:
  - Parameterised 1-bit FIFO.
  - Ports: push, pop, din, dout, full, empty, count.
  - Asynchronous active-low reset.

Test Plan:
- Single fetch, addr 0x0000_0100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF → instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
- Both request, DATA_PRIORITY=1, data addr 0x2000_0004 we=1 be=4'b0011 → data_gnt_o=1 first, mem_be_o=4'b0011; instruction granted next cycle with be=4'hF, we=0.
- DATA_PRIORITY=0, both requesting continuously → grants alternate instr, data, instr, data…; responses return to the matching owner in order.
- Hold mem_gnt_i=0 for 3 cycles with instruction owning, data asserting req on cycle 2 → mem_addr_o stays the instruction address until gnt; data is granted afterwards.
- MAX_OUTSTANDING=2, two accepts with no rvalid:
  - mem_req_o=0 while full.
  - rvalid in the same cycle as a new request still blocks.
  - Request is accepted the following cycle.
- mem_rvalid_i with empty FIFO (also right after releasing rst_n mid-transaction) → no rvalid forwarded; unexp_rsp_o pulses high exactly one cycle later.
